// File: rtl/exe_stage.sv
// Execute stage of the 8-bit pipelined RISC core.
// It forwards operands, runs the ALU or a shift-add multiplier, updates the
// status register and output port, and registers its results into EX/MEM.
//
// Handshake: there is no valid/ready pair here. stall=1 means the ID/EX
// register and everything upstream must hold. Every rising edge with stall=0
// commits the instruction presented on the inputs. Every edge with stall=1
// loads a bubble: the write/read enables drop, the data fields hold, and SR
// and out_port_data stay unchanged.
module exe_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic              S,
    input  logic              inPort,
    input  logic              outPort,
    input  logic [3:0]        EXE_CMD,
    input  logic [DATA_W-1:0] Val_Ra,
    input  logic [DATA_W-1:0] Val_Rb,
    input  logic              imm,
    input  logic [DATA_W-1:0] Val_Imm,
    input  logic [REG_AW-1:0] Dest,
    input  logic [1:0]        fwd_a_sel,
    input  logic [1:0]        fwd_b_sel,
    input  logic [DATA_W-1:0] mem_fwd_val,
    input  logic [DATA_W-1:0] wb_fwd_val,
    input  logic [DATA_W-1:0] in_port_data,
    output logic              stall,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic              MEM_W_EN_out,
    output logic [DATA_W-1:0] ALU_Res,
    output logic [DATA_W-1:0] St_Val,
    output logic [REG_AW-1:0] Dest_out,
    output logic [3:0]        SR,
    output logic [DATA_W-1:0] out_port_data
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [3:0] CMD_MOV = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_AND = 4'd3;
    localparam logic [3:0] CMD_OR  = 4'd4;
    localparam logic [3:0] CMD_XOR = 4'd5;
    localparam logic [3:0] CMD_SHL = 4'd6;
    localparam logic [3:0] CMD_SHR = 4'd7;
    localparam logic [3:0] CMD_MUL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // Multiplier FSM state, kept as a named signal so checkers can bind to it.
    mul_state_t state;

    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [DATA_W-1:0]   lat_a;
    logic [DATA_W-1:0]   lat_bf;

    logic [DATA_W-1:0] a_fwd, bf_fwd, b_sel;
    logic [DATA_W-1:0] a_op, bf_op;
    logic [DATA_W-1:0] alu_res, res_final;
    logic [DATA_W:0]   sum_ext;
    logic              flag_c, flag_v, flag_z, flag_n;

    // Operand forwarding muxes; selects 0 and 3 both take the register value.
    always_comb begin
        a_fwd  = Val_Ra;
        bf_fwd = Val_Rb;
        case (fwd_a_sel)
            2'd1:    a_fwd = mem_fwd_val;
            2'd2:    a_fwd = wb_fwd_val;
            default: a_fwd = Val_Ra;
        endcase
        case (fwd_b_sel)
            2'd1:    bf_fwd = mem_fwd_val;
            2'd2:    bf_fwd = wb_fwd_val;
            default: bf_fwd = Val_Rb;
        endcase
        b_sel = imm ? Val_Imm : bf_fwd;
        // Once a multiply has started the forwarding network may have moved
        // on, so the operands captured at multiply start are used instead.
        a_op  = (state == ST_IDLE) ? a_fwd  : lat_a;
        bf_op = (state == ST_IDLE) ? bf_fwd : lat_bf;
    end

    // Stall while a multiply is starting or iterating; reset forces it low.
    assign stall = !rst && (((state == ST_IDLE) && (EXE_CMD == CMD_MUL)) ||
                            (state == ST_MUL));

    // ALU, port override and flag generation for the committing instruction.
    always_comb begin
        alu_res = '0;
        flag_c  = 1'b0;
        flag_v  = 1'b0;
        sum_ext = '0;
        case (EXE_CMD)
            CMD_MOV: alu_res = b_sel;
            CMD_ADD: begin
                sum_ext = {1'b0, a_op} + {1'b0, b_sel};
                alu_res = sum_ext[DATA_W-1:0];
                flag_c  = sum_ext[DATA_W];
                flag_v  = (a_op[DATA_W-1] == b_sel[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_op[DATA_W-1]);
            end
            CMD_SUB: begin
                alu_res = a_op - b_sel;
                flag_c  = (a_op < b_sel);
                flag_v  = (a_op[DATA_W-1] != b_sel[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_op[DATA_W-1]);
            end
            CMD_AND: alu_res = a_op & b_sel;
            CMD_OR:  alu_res = a_op | b_sel;
            CMD_XOR: alu_res = a_op ^ b_sel;
            CMD_SHL: begin
                alu_res = {a_op[DATA_W-2:0], 1'b0};
                flag_c  = a_op[DATA_W-1];
            end
            CMD_SHR: begin
                alu_res = {1'b0, a_op[DATA_W-1:1]};
                flag_c  = a_op[0];
            end
            CMD_MUL: begin
                alu_res = acc[DATA_W-1:0];
                flag_c  = |acc[2*DATA_W-1:DATA_W];
            end
            default: alu_res = '0;
        endcase
        res_final = inPort ? in_port_data : alu_res;
        flag_z    = (res_final == '0);
        flag_n    = res_final[DATA_W-1];
    end

    // Shift-add multiplier: one multiplier bit per cycle, DATA_W iterations.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            lat_a  <= '0;
            lat_bf <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (EXE_CMD == CMD_MUL) begin
                        lat_a  <= a_fwd;
                        lat_bf <= bf_fwd;
                        mcand  <= {{DATA_W{1'b0}}, a_fwd};
                        mplier <= b_sel;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= {mcand[2*DATA_W-2:0], 1'b0};
                    mplier <= {1'b0, mplier[DATA_W-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // EX/MEM boundary registers: commit when not stalled, bubble otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_EN_out     <= 1'b0;
            MEM_R_EN_out  <= 1'b0;
            MEM_W_EN_out  <= 1'b0;
            ALU_Res       <= '0;
            St_Val        <= '0;
            Dest_out      <= '0;
            SR            <= '0;
            out_port_data <= '0;
        end else if (stall) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
        end else begin
            WB_EN_out    <= WB_EN;
            MEM_R_EN_out <= MEM_R_EN;
            MEM_W_EN_out <= MEM_W_EN;
            ALU_Res      <= res_final;
            St_Val       <= bf_op;
            Dest_out     <= Dest;
            if (S) begin
                SR <= {flag_z, flag_n, flag_c, flag_v};
            end
            if (outPort) begin
                out_port_data <= a_op;
            end
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage: reset, ALU, forwarding, multiplier
// timing, reset during a multiply, and the I/O ports.
module tb_exe_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       WB_EN, MEM_R_EN, MEM_W_EN, S, inPort, outPort;
    logic [3:0] EXE_CMD;
    logic [7:0] Val_Ra, Val_Rb, Val_Imm;
    logic       imm;
    logic [1:0] Dest;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [7:0] mem_fwd_val, wb_fwd_val, in_port_data;
    logic       stall;
    logic       WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
    logic [7:0] ALU_Res, St_Val, out_port_data;
    logic [1:0] Dest_out;
    logic [3:0] SR;

    int tests = 0;
    int fails = 0;
    int n;

    exe_stage #(.DATA_W(8), .REG_AW(2)) dut (
        .clk(clk), .rst(rst),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .S(S), .inPort(inPort), .outPort(outPort),
        .EXE_CMD(EXE_CMD), .Val_Ra(Val_Ra), .Val_Rb(Val_Rb),
        .imm(imm), .Val_Imm(Val_Imm), .Dest(Dest),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .in_port_data(in_port_data),
        .stall(stall),
        .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
        .MEM_W_EN_out(MEM_W_EN_out),
        .ALU_Res(ALU_Res), .St_Val(St_Val), .Dest_out(Dest_out),
        .SR(SR), .out_port_data(out_port_data)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0; S = 0;
        inPort = 0; outPort = 0; EXE_CMD = 4'd0;
        Val_Ra = 8'h00; Val_Rb = 8'h00; imm = 0; Val_Imm = 8'h00;
        Dest = 2'd0; fwd_a_sel = 2'd0; fwd_b_sel = 2'd0;
        mem_fwd_val = 8'h00; wb_fwd_val = 8'h00; in_port_data = 8'h00;
    endtask

    // Runs one multiply a*b and checks stall length, bubbles and the commit.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_res, input logic [3:0] exp_sr,
                           input string tag);
        clr();
        EXE_CMD = 4'd8; Val_Ra = a; Val_Rb = b; S = 1; WB_EN = 1; Dest = 2'd3;
        #1;
        check({tag, "_stall_start"}, {15'd0, stall}, 16'd1);
        n = 0;
        while (stall && n < 20) begin
            tick();
            n++;
            check({tag, "_bubble_wb"}, {15'd0, WB_EN_out}, 16'd0);
        end
        check({tag, "_stall_cycles"}, 16'(n), 16'd9);
        // Forwarding changes now must not affect the result.
        fwd_a_sel = 2'd1; mem_fwd_val = 8'hFF;
        fwd_b_sel = 2'd2; wb_fwd_val = 8'hFF;
        tick();
        check({tag, "_res"}, {8'd0, ALU_Res}, {8'd0, exp_res});
        check({tag, "_sr"}, {12'd0, SR}, {12'd0, exp_sr});
        check({tag, "_wb"}, {15'd0, WB_EN_out}, 16'd1);
        check({tag, "_dest"}, {14'd0, Dest_out}, 16'd3);
        check({tag, "_stval"}, {8'd0, St_Val}, {8'd0, b});
    endtask

    // Directed stimulus.
    initial begin
        clr();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        check("rst_stall", {15'd0, stall}, 16'd0);
        check("rst_alu", {8'd0, ALU_Res}, 16'd0);
        check("rst_sr", {12'd0, SR}, 16'd0);
        check("rst_outp", {8'd0, out_port_data}, 16'd0);

        // ADD with immediate: 0x7F + 1 = 0x80, N=1 V=1.
        clr();
        EXE_CMD = 4'd1; Val_Ra = 8'h7F; imm = 1; Val_Imm = 8'h01;
        Val_Rb = 8'h55; S = 1; WB_EN = 1; Dest = 2'd1;
        tick();
        check("add_res", {8'd0, ALU_Res}, 16'h0080);
        check("add_sr", {12'd0, SR}, 16'b0101);
        check("add_wb", {15'd0, WB_EN_out}, 16'd1);
        check("add_stval", {8'd0, St_Val}, 16'h0055);
        check("add_dest", {14'd0, Dest_out}, 16'd1);

        // Same op with S=0 and a zero result: SR must hold.
        Val_Ra = 8'h00; Val_Imm = 8'h00; S = 0;
        tick();
        check("adds0_res", {8'd0, ALU_Res}, 16'h0000);
        check("adds0_sr", {12'd0, SR}, 16'b0101);

        // Reset for two cycles mid-stream.
        rst = 1;
        tick();
        tick();
        rst = 0;
        check("mrst_alu", {8'd0, ALU_Res}, 16'd0);
        check("mrst_stval", {8'd0, St_Val}, 16'd0);
        check("mrst_wb", {15'd0, WB_EN_out}, 16'd0);
        check("mrst_sr", {12'd0, SR}, 16'd0);
        check("mrst_stall", {15'd0, stall}, 16'd0);

        // Forwarding: mem 0x10 - wb 0x03 = 0x0D.
        clr();
        EXE_CMD = 4'd2; Val_Ra = 8'hEE; Val_Rb = 8'hEE;
        fwd_a_sel = 2'd1; mem_fwd_val = 8'h10;
        fwd_b_sel = 2'd2; wb_fwd_val = 8'h03;
        tick();
        check("fwd_sub_res", {8'd0, ALU_Res}, 16'h000D);
        check("fwd_sub_stval", {8'd0, St_Val}, 16'h0003);
        check("fwd_sub_sr", {12'd0, SR}, 16'd0);

        // 0x10 - 0x20 = 0xF0 with borrow.
        fwd_b_sel = 2'd0; Val_Rb = 8'h20; S = 1;
        tick();
        check("sub_borrow_res", {8'd0, ALU_Res}, 16'h00F0);
        check("sub_borrow_sr", {12'd0, SR}, 16'b0110);

        // Select 3 takes register values: 0x40 - 0x40 = 0, Z=1.
        fwd_a_sel = 2'd3; Val_Ra = 8'h40; fwd_b_sel = 2'd3; Val_Rb = 8'h40;
        tick();
        check("sel3_res", {8'd0, ALU_Res}, 16'h0000);
        check("sel3_sr", {12'd0, SR}, 16'b1000);

        // Shifts.
        clr();
        EXE_CMD = 4'd6; Val_Ra = 8'h81; S = 1;
        tick();
        check("shl_res", {8'd0, ALU_Res}, 16'h0002);
        check("shl_sr", {12'd0, SR}, 16'b0010);
        EXE_CMD = 4'd7; Val_Ra = 8'h01;
        tick();
        check("shr_res", {8'd0, ALU_Res}, 16'h0000);
        check("shr_sr", {12'd0, SR}, 16'b1010);

        // Logic op and an unused opcode.
        clr();
        EXE_CMD = 4'd5; Val_Ra = 8'hF0; Val_Rb = 8'h3C; S = 1;
        tick();
        check("xor_res", {8'd0, ALU_Res}, 16'h00CC);
        check("xor_sr", {12'd0, SR}, 16'b0100);
        EXE_CMD = 4'd9; Val_Ra = 8'h05; Val_Rb = 8'h03; S = 0;
        tick();
        check("op9_res", {8'd0, ALU_Res}, 16'h0000);

        // Multiplies, the second directly following the first.
        run_mul(8'h12, 8'h10, 8'h20, 4'b0010, "mul1");
        run_mul(8'h03, 8'h05, 8'h0F, 4'b0000, "mul2");
        clr();
        tick();

        // Reset during the 4th stall cycle of a multiply.
        clr();
        EXE_CMD = 4'd8; Val_Ra = 8'h07; Val_Rb = 8'h09; S = 1; WB_EN = 1;
        #1;
        check("rmul_stall1", {15'd0, stall}, 16'd1);
        tick();
        tick();
        tick();
        check("rmul_stall4", {15'd0, stall}, 16'd1);
        rst = 1;
        #1;
        check("rmul_stall_rst", {15'd0, stall}, 16'd0);
        tick();
        rst = 0;
        clr();
        EXE_CMD = 4'd1; Val_Ra = 8'h02; imm = 1; Val_Imm = 8'h02; WB_EN = 1;
        #1;
        check("rmul_nocommit_res", {8'd0, ALU_Res}, 16'd0);
        check("rmul_nocommit_wb", {15'd0, WB_EN_out}, 16'd0);
        check("rmul_nocommit_sr", {12'd0, SR}, 16'd0);
        check("rmul_idle_stall", {15'd0, stall}, 16'd0);
        tick();
        check("rmul_add_res", {8'd0, ALU_Res}, 16'h0004);
        check("rmul_add_wb", {15'd0, WB_EN_out}, 16'd1);

        // Output port load then hold.
        clr();
        outPort = 1; Val_Ra = 8'hA5;
        tick();
        check("outp_load", {8'd0, out_port_data}, 16'h00A5);
        outPort = 0; Val_Ra = 8'h11;
        tick();
        check("outp_hold", {8'd0, out_port_data}, 16'h00A5);

        // Input port overrides the ALU.
        clr();
        inPort = 1; in_port_data = 8'h3C; Dest = 2'd2; WB_EN = 1;
        EXE_CMD = 4'd1; Val_Ra = 8'h01; Val_Rb = 8'h01;
        tick();
        check("inp_res", {8'd0, ALU_Res}, 16'h003C);
        check("inp_dest", {14'd0, Dest_out}, 16'd2);
        check("inp_wb", {15'd0, WB_EN_out}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 8-bit pipelined RISC core. It sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- It does operand forwarding, ALU operations, a multi-cycle shift-add multiplier, the status register and the output port.
- It registers its results into the EX/MEM boundary, so its outputs are the MEM-stage inputs.
- It drives a stall back to the front end while a multiply is in progress.

Parameters:
- DATA_W, 8, datapath width; the multiplier iterates DATA_W cycles.
- REG_AW, 2, register-address width (4 architectural registers).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- WB_EN, MEM_R_EN, MEM_W_EN, S, inPort, outPort  in  1 each  control bits from the ID/EX register.
- EXE_CMD  in  4  ALU opcode.
- Val_Ra, Val_Rb  in  DATA_W  register operands.
- imm  in  1  1 = operand B is Val_Imm.
- Val_Imm  in  DATA_W  immediate value.
- Dest  in  REG_AW  destination register.
- fwd_a_sel, fwd_b_sel  in  2 each  forwarding select: 0 = register value, 1 = mem_fwd_val, 2 = wb_fwd_val, 3 = register value.
- mem_fwd_val, wb_fwd_val  in  DATA_W  forwarded results.
- in_port_data  in  DATA_W  external input port.
- stall  out  1  hold the ID/EX register and all upstream stages.
- WB_EN_out, MEM_R_EN_out, MEM_W_EN_out  out  1 each  registered controls to MEM.
- ALU_Res  out  DATA_W  registered result.
- St_Val  out  DATA_W  registered store data (forwarded B register operand, never the immediate).
- Dest_out  out  REG_AW  registered destination.
- SR  out  4  status register {Z,N,C,V}.
- out_port_data  out  DATA_W  output-port register.

Behaviour:
- Reset: all registered outputs are 0, SR is 0, out_port_data is 0, FSM is IDLE, stall is 0. A reset during a multiply aborts it; no partial result is written.
- Operands:
  - A = forwarded Ra.
  - Bf = forwarded Rb.
  - B = imm ? Val_Imm : Bf.
- EXE_CMD encoding (all results are DATA_W bits):
  - 0 MOV: result = B.
  - 1 ADD: result = A+B.
  - 2 SUB: result = A-B.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SHL: A<<1.
  - 7 SHR: A>>1, logical.
  - 8 MUL: low byte of A*B.
  - 9-15: result = 0.
- Ports override the ALU:
  - inPort=1: result = in_port_data, sampled in the commit cycle.
  - outPort=1: out_port_data <= A at commit; it holds otherwise.
- Flags (written at commit only when S=1; SR holds otherwise):
  - Z = result==0. N = result[7].
  - ADD: C = carry out, V = signed overflow.
  - SUB: C = borrow (A<B unsigned), V = signed overflow.
  - SHL/SHR: C = the shifted-out bit, V = 0.
  - MUL: C = (product[15:8]!=0), V = 0.
  - Logic ops and MOV: C = 0, V = 0.
- Commit: a rising edge with stall=0 loads the output registers from the current inputs.
- Bubble: while stall=1, the output registers load a bubble (WB_EN_out, MEM_R_EN_out, MEM_W_EN_out = 0; data fields hold). SR and out_port_data do not change during a bubble.
- Single-cycle ops: result is visible at the outputs 1 cycle after presentation.
- Multiply FSM, states IDLE, MUL, DONE:
  - IDLE, EXE_CMD=8: stall=1 combinationally. The FSM latches A and B and clears the accumulator and counter. Next state is MUL.
  - MUL: stall=1. Each cycle, if multiplier bit0 is set the accumulator adds the shifted multiplicand; then the multiplicand shifts left, the multiplier shifts right and cnt increments. After cnt reaches DATA_W-1, next state is DONE.
  - DONE: stall=0. The instruction commits with the product. Next state is IDLE, and the ID/EX register advances on the same edge.
  - Total: stall is high for DATA_W+1 cycles (9), and the result appears after cycle 10.
- Forwarding selects are ignored during MUL and DONE; the latched operands are used.
- A MUL directly following a MUL restarts from IDLE normally.
- ADD/SUB wrap modulo 2^DATA_W.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream → all outputs 0, SR=0000, stall=0.
- ADD with imm: Val_Ra=0x7F, imm=1, Val_Imm=0x01, S=1, WB_EN=1 → next cycle ALU_Res=0x80 and SR={Z0,N1,C0,V1}. Repeat with S=0 → SR unchanged.
- Forwarding: fwd_a_sel=1, mem_fwd_val=0x10, fwd_b_sel=2, wb_fwd_val=0x03, SUB → ALU_Res=0x0D. Then fwd_b_sel=0, Val_Rb=0x20, SUB, S=1 → ALU_Res=0xF0, C=1.
- MUL: A=0x12, B=0x10, S=1 → stall high exactly 9 cycles with WB_EN_out=0 throughout, then ALU_Res=0x20 and C=1. Repeat with A=3, B=5 → ALU_Res=0x0F, C=0.
- Reset during MUL: assert rst at the 4th stall cycle → FSM IDLE, stall=0, no commit. Then a following ADD 2+2 → ALU_Res=0x04.
- Ports: outPort=1, A=0xA5 → out_port_data=0xA5 and it holds. inPort=1, in_port_data=0x3C, Dest=2, WB_EN=1 → ALU_Res=0x3C, Dest_out=2.
